// File: rtl/ifu_pkg.sv
// Shared types and sizes for the instruction fetch unit and its prefetch buffer.
package ifu_pkg;

   localparam int INS_W     = 24;
   localparam int PC_W      = 8;
   localparam int IFU_DEPTH = 4;
   localparam int CNT_W     = $clog2(IFU_DEPTH + 1);

   localparam logic [INS_W-1:0] NOP_INS = 24'h000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [INS_W-1:0] ins;
      logic [PC_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: small FIFO of {instruction, pc} entries with synchronous flush.
module ifu_fifo
   import ifu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     push_entry,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(IFU_DEPTH);

   fetch_entry_t     mem_q [IFU_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(IFU_DEPTH)) || do_pop);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues reads to a 1-cycle synchronous imem and queues results.
module instruction_fetch_unit
   import ifu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_en,
   input  logic             redirect_en,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic             imem_en,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [INS_W-1:0] imem_rdata,
   output logic [INS_W-1:0] ins,
   output logic             ins_valid,
   input  logic             ins_ready,
   output logic [PC_W-1:0]  ins_pc,
   output logic [2:0]       buf_count
);

   ifu_state_e       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  ret_pc_q, ret_pc_d;
   logic             inflight_q, inflight_d;
   logic             discard_q, discard_d;

   logic             fifo_push, fifo_pop;
   fetch_entry_t     push_entry, head;
   logic [CNT_W-1:0] fifo_count;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ins_valid  = (fifo_count != '0);
      ins        = ins_valid ? head.ins : NOP_INS;
      ins_pc     = ins_valid ? head.pc : '0;
      fifo_pop   = ins_valid && ins_ready;
      fifo_push  = inflight_q && !discard_q && !redirect_en;
      push_entry = '{ins: imem_rdata, pc: ret_pc_q};
      // An in-flight read already holds a slot, so it counts against the depth.
      imem_en    = (state_q == RUN) && fetch_en &&
                   ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(IFU_DEPTH));
      imem_addr  = pc_q;
      inflight_d = imem_en;
      ret_pc_d   = pc_q;
      discard_d  = imem_en && redirect_en;
      if (imem_en) pc_d = pc_q + 1'b1;

      case (state_q)
         IDLE:    if (fetch_en) state_d = RUN;
         RUN:     if (!fetch_en && !inflight_q) state_d = IDLE;
         FLUSH:   state_d = fetch_en ? RUN : IDLE;
         default: state_d = IDLE;
      endcase

      if (redirect_en) begin
         state_d = FLUSH;
         pc_d    = redirect_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         ret_pc_q   <= '0;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ret_pc_q   <= ret_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   ifu_fifo u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .pop        (fifo_pop),
      .flush      (redirect_en),
      .push_entry (push_entry),
      .head       (head),
      .count      (fifo_count)
   );

   assign buf_count = fifo_count;

endmodule
